// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage RV32I core.
// It drives the enable and flush controls of the PC and the four inter-stage
// registers. It handles three kinds of hazard:
//   - load-use: stall the front end for one cycle and insert a bubble,
//   - taken redirect: flush IF/ID and ID/EX,
//   - multi-cycle data-memory access: freeze the pipe, with a timeout watchdog.
// Optional build macro HAZARD_PERF_EN adds the stall and flush event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_flush,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             wait_now;
  logic             load_use;

  // The memory stall depends only on the current request. It therefore
  // covers the first wait cycle, while the state is still RUN.
  assign wait_now = mem_req & ~mem_ready;

  // x0 is hard-wired to zero, so a match on it is never a real dependency.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // The next count saturates so that a long wait cannot wrap back below the timeout.
  assign cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  // Prioritised control decode (memory > redirect > load-use) and FSM next state.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_nxt    = state;

    if (!rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (wait_now) begin
      // Freeze everything up to EX. The bubble into WB stops the MEM
      // instruction from retiring twice.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    case (state)
      RUN:      if (wait_now)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample their inputs before any of them update.
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Wait counter: counts stalled cycles and clears when no wait is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            wait_cnt <= '0;
    else if (wait_now)                   wait_cnt <= cnt_inc;
    else if (state == RUN || mem_ready)  wait_cnt <= '0;
  end

  // Sticky timeout flag. It sets on the edge where the count reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                mem_err <= 1'b0;
    else if (wait_now && cnt_inc >= TIMEOUT) mem_err <= 1'b1;
  end

`ifdef HAZARD_PERF_EN
  // Event counters. They count only the hazard actually applied after priority resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (wait_now || (!ex_redirect && load_use))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (!wait_now && ex_redirect)
        perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Directed scenarios run first, then
// random traffic. Every cycle is compared against a cycle-level model of the
// control rules. Define HAZARD_PERF_EN to also cover the event counters.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .mem_err      (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: whether a wait is outstanding, the wait length, the sticky
  // error flag and the event counts.
  bit          m_wait;
  int          m_cnt;
  bit          m_err;
  int unsigned m_stall, m_flush;

  task automatic model_clear();
    m_wait = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic bit hazard_lu();
    return ex_is_load && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes}.
  function automatic logic [7:0] exp_ctrl();
    if (!rst)                      return 8'b0000_0000;
    if (mem_req && !mem_ready)     return 8'b0000_1001; // frozen, WB bubble
    if (ex_redirect)               return 8'b1111_1110; // squash two younger
    if (hazard_lu())               return 8'b0011_1010; // hold front, bubble EX
    return 8'b1111_1000;
  endfunction

  task automatic update_model();
    bit wn;
    if (!rst) begin
      model_clear();
      return;
    end
    wn = mem_req && !mem_ready;
    if (wn || (!ex_redirect && hazard_lu())) m_stall++;
    if (!wn && ex_redirect)                  m_flush++;
    if (wn) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_cnt >= TIMEOUT) m_err = 1;
      m_wait = 1;
    end else begin
      if (!m_wait || mem_ready) m_cnt = 0;
      if (mem_ready) m_wait = 0;
    end
  endtask

  task automatic check_outputs();
    check("ctrl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_flush}, {24'd0, exp_ctrl()});
    check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    check("wait_cnt", {16'd0, dut.wait_cnt}, m_cnt);
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cycles, m_stall);
    check("perf_flush", perf_flush_events, m_flush);
`endif
  endtask

  // Inputs change at posedge+1. Outputs are compared at posedge+4, then the
  // model advances on the edge.
  task automatic tick();
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic step();
    #3;
    tick();
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_is_load = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    model_clear();
    step();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1; ex_rd = rd; id_rs1 = 5'd7; id_rs2 = rd;
    id_use_rs1 = 1; id_use_rs2 = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

`ifdef HAZARD_PERF_EN
    // Two load-use stalls, three wait cycles and one redirect.
    set_load_use(5'd5); step();
    idle_inputs(); step();
    set_load_use(5'd9); step();
    idle_inputs(); mem_req = 1; step(); step(); step();
    mem_ready = 1; step();
    idle_inputs(); ex_redirect = 1; step();
    idle_inputs(); #3;
    check("perf_stall_total", perf_stall_cycles, 32'd5);
    check("perf_flush_total", perf_flush_events, 32'd1);
    tick();
`endif

    // Load-use on rs2: stall for exactly one cycle.
    idle_inputs();
    ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1; #3;
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_if_id_en", {31'd0, if_id_en}, 32'd0);
    check("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();
    ex_is_load = 0; #3;                 // load has moved on to MEM
    check("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    // The same pattern against x0 never stalls.
    ex_is_load = 1; ex_rd = 5'd0; id_rs2 = 5'd0; #3;
    check("lu_x0_pc_en", {31'd0, pc_en}, 32'd1);
    tick();

    // Redirect for a single cycle.
    idle_inputs(); ex_redirect = 1; #3;
    check("redir_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    check("redir_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    ex_redirect = 0; step();
    // Redirect together with a load-use match: flush only, no stall.
    set_load_use(5'd3); ex_redirect = 1; #3;
    check("redir_lu_pc_en", {31'd0, pc_en}, 32'd1);
    check("redir_lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();

    // Memory wait: three cycles with ready low, then ready.
    idle_inputs(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("mw_ex_mem_en", {31'd0, ex_mem_en}, 32'd0);
      check("mw_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
      tick();
    end
    mem_ready = 1; #3;
    check("mw_done_ex_mem_en", {31'd0, ex_mem_en}, 32'd1);
    tick();
    idle_inputs(); #3;
    check("mw_cnt_cleared", {16'd0, dut.wait_cnt}, 32'd0);
    tick();

    // A memory stall takes priority over a redirect. The redirect flush then
    // applies in the cycle ready rises.
    mem_req = 1; ex_redirect = 1; #3;
    check("prio_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    check("prio_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
    tick();
    mem_ready = 1; #3;
    check("prio_late_flush", {31'd0, if_id_flush}, 32'd1);
    tick();

    // Timeout: the error sets on the 4th wait edge and stays set.
    do_reset();
    mem_req = 1;
    repeat (3) step();
    #3;
    check("to_before", {31'd0, mem_err}, 32'd0);
    tick();
    #3;
    check("to_set", {31'd0, mem_err}, 32'd1);
    tick();
    mem_ready = 1; step();
    idle_inputs(); #3;
    check("to_sticky", {31'd0, mem_err}, 32'd1);
    tick();
    // Drop reset in the middle of a wait: outputs go to reset values at once.
    mem_req = 1; step(); step();
    #2 rst = 1'b0;
    model_clear();
    #1;
    check("rst_ctrl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush}, 32'd0);
    check("rst_wait_cnt", {16'd0, dut.wait_cnt}, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    tick();
    @(posedge clk);
    #1 rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        model_clear();
      end else begin
        rst = 1'b1;
      end
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_is_load  = ($urandom_range(0, 99) < 50);
      ex_redirect = ($urandom_range(0, 99) < 20);
      mem_req     = ($urandom_range(0, 99) < 35);
      mem_ready   = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It drives the enable and flush controls of the PC and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three hazard classes:

- load-use data hazards, by stalling and inserting a bubble;
- taken branches and jumps, by flushing two stages;
- multi-cycle data-memory accesses, by freezing the pipe, with a timeout watchdog.

Stage registers realise a flush by muxing a zero D input under the `*_flush` outputs.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of consecutive wait cycles before `mem_err` is raised; range 1..65535.
- `CNT_W`, default 16: width of the wait counter; must satisfy 2^CNT_W > `MEM_TIMEOUT`.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-low reset (`rst`=0 resets immediately).
- `id_rs1`, `id_rs2` input, 5: source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` input, 1: the ID instruction actually reads rs1 / rs2.
- `ex_rd` input, 5: destination register of the instruction in EX.
- `ex_is_load` input, 1: the EX instruction is a load.
- `ex_redirect` input, 1: taken branch or jump resolved in EX this cycle.
- `mem_req` input, 1: the MEM-stage instruction accesses data memory.
- `mem_ready` input, 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` output, 1: load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` output, 1: load zero (bubble) instead of D.
- `mem_err` output, 1: sticky memory-timeout flag.

## Operation

- FSM states: RUN and MEM_WAIT. Reset state is RUN.
  - RUN → MEM_WAIT when `mem_req` & !`mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`.
  - MEM_WAIT → MEM_WAIT otherwise.
- The wait stall is combinational from `mem_req` & !`mem_ready`, so it applies in the first wait cycle, while the state is still RUN.
- Memory stall (highest priority), when `mem_req` & !`mem_ready`:
  - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0.
  - `mem_wb_en`=1 and `mem_wb_flush`=1, so the bubble prevents a repeated WB.
  - All other flushes are 0. Redirect and load-use requests are ignored; the frozen EX stage re-presents them after the stall.
- Redirect (second priority), when `ex_redirect`:
  - All enables are 1.
  - `if_id_flush`=1 and `id_ex_flush`=1, which squashes the two younger instructions, including any load-use victim.
- Load-use (third priority), when `ex_is_load` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)):
  - `pc_en`=0 and `if_id_en`=0.
  - `id_ex_en`=1 and `id_ex_flush`=1.
  - `ex_mem_en`=1 and `mem_wb_en`=1.
- Otherwise all enables are 1 and all flushes are 0.
- A comparison against x0 never stalls.
- Wait counter `wait_cnt` (`CNT_W` bits):
  - Cleared in RUN when no wait is pending and on wait completion.
  - Increments each cycle that `mem_req` & !`mem_ready` holds, and saturates at its maximum value.
- When `wait_cnt` reaches `MEM_TIMEOUT`, `mem_err` sets on that edge. It stays set until reset.
- The stall continues after a timeout; recovery is system-level.

## Timing

- Control outputs are combinational from the inputs and state, with zero latency: a hazard present in cycle N gates the edge that ends cycle N.
- Load-use stall lasts exactly one cycle. On the next cycle the load has moved to MEM, so the compare no longer matches.
- A redirect costs 2 bubbles.
- A memory wait costs k stall cycles, where k is the number of cycles with `mem_ready`=0.
- Reset values while `rst`=0:
  - FSM state = RUN, `wait_cnt`=0, `mem_err`=0.
  - All enables 0 and all flushes 0, regardless of the inputs.
- Reset asserted mid-wait forces RUN and `wait_cnt`=0 immediately.
- First release edge: normal RUN decoding.

## Configuration

- `HAZARD_PERF_EN` defined: adds two 32-bit outputs, `perf_stall_cycles` and `perf_flush_events`.
  - `perf_stall_cycles` increments for every memory-stall or load-use cycle.
  - `perf_flush_events` increments once per cycle in which a redirect flush is applied.
  - Both reset to 0, wrap modulo 2^32, and are async-reset by `rst`.
- `HAZARD_PERF_EN` undefined: the ports and counters are absent. Control behaviour is identical in both cases.

## Test plan

- Load-use: EX lw with `ex_rd`=5, ID add with `id_rs2`=5 and `id_use_rs2`=1.
  - Expect `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 for exactly 1 cycle, then all enables 1.
  - Repeat with `ex_rd`=0: expect no stall.
- Redirect: `ex_redirect`=1 for one cycle.
  - Expect `if_id_flush`=1 and `id_ex_flush`=1 for that cycle only, with `pc_en`=1.
  - Redirect coincident with a load-use match: expect flush only, `pc_en`=1.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles, then high.
  - Expect 3 cycles of `ex_mem_en`=0 with `mem_wb_flush`=1, state MEM_WAIT, then RUN with `wait_cnt`=0.
- Priority: `mem_req`=1, `mem_ready`=0 and `ex_redirect`=1 together.
  - Expect a frozen pipe with no IF/ID or ID/EX flush.
  - The redirect flush applies in the cycle `mem_ready` rises.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` held 0.
  - Expect `mem_err`=1 after the 4th wait edge, still 1 after `mem_ready` returns.
  - Expect `mem_err`=0 only after `rst` is pulsed low; drop `rst` mid-wait and check that all outputs go to their reset values immediately.
- With `HAZARD_PERF_EN`: 2 load-use stalls, 3 memory-wait cycles and 1 redirect.
  - Expect `perf_stall_cycles`=5 and `perf_flush_events`=1.
